// File: rtl/instruction_fetch_controller_pkg.sv
// Shared constants and types for the instruction fetch controller slice:
// FSM encodings, instruction width, PC step and the IF/ID payload record.
`ifndef INSTRUCTION_FETCH_CONTROLLER_PKG_SV
`define INSTRUCTION_FETCH_CONTROLLER_PKG_SV

package instruction_fetch_controller_pkg;

  localparam int          INSTR_WIDTH  = 32;
  localparam logic [31:0] PC_INCREMENT = 32'd4;

  localparam logic [1:0] FETCH_STATE_BOOT  = 2'd0;
  localparam logic [1:0] FETCH_STATE_FETCH = 2'd1;
  localparam logic [1:0] FETCH_STATE_HALT  = 2'd2;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instruction;
    logic [31:0]            pc;
    logic [31:0]            pc_plus4;
  } fetch_word_t;

  // Word-aligns a byte address by clearing the two byte-offset bits.
  function automatic logic [31:0] align_word(input logic [31:0] byte_address);
    return {byte_address[31:2], 2'b00};
  endfunction

endpackage

`endif

// File: rtl/instruction_fetch_controller_if.sv
// IF/ID boundary bundle: valid/ready handshake plus the fetched word and its
// program counter values. The fetch side is master, decode is slave.
interface instruction_fetch_controller_if;
  import instruction_fetch_controller_pkg::*;

  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instruction;
  logic [31:0]            out_pc;
  logic [31:0]            out_pc_plus4;

  modport master (
    output out_valid,
    input  out_ready,
    output out_instruction,
    output out_pc,
    output out_pc_plus4
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_instruction,
    input  out_pc,
    input  out_pc_plus4
  );

endinterface

// File: rtl/instruction_fetch_controller_fetch_output_register.sv
// IF/ID pipeline register: loads on a fetch, holds while decode stalls,
// drops valid on a flush or when the held word is consumed.
module fetch_output_register
  import instruction_fetch_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  fetch_word_t load_word,
  instruction_fetch_controller_if.master out_bus
);

  logic        valid_q;
  fetch_word_t word_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (flush) begin
      // Flush only invalidates; the stale payload is never presented as valid.
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      word_q  <= load_word;
    end else if (valid_q && out_bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_bus.out_valid       = valid_q;
  assign out_bus.out_instruction = word_q.instruction;
  assign out_bus.out_pc          = word_q.pc;
  assign out_bus.out_pc_plus4    = word_q.pc_plus4;

endmodule

// File: rtl/instruction_fetch_controller.sv
// Front-end fetch sequencer: owns the PC and the BOOT/FETCH/HALT FSM, reads
// instruction memory combinationally and feeds the IF/ID register.
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter int          SIZE_EXP2   = 10,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic                   system_clock,
  input  logic                   system_reset,
  output logic [SIZE_EXP2-1:0]   imem_address,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   halt_request,
  instruction_fetch_controller_if.master out_bus,
  output logic                   halted,
  output logic                   fault
);

  // One past the last byte address backed by instruction memory; 33 bits so
  // the bound stays representable for the largest memories.
  localparam logic [32:0] PC_LIMIT  = 33'd4 << SIZE_EXP2;
  localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [3:0]  boot_count;
  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic        fault_q;

  logic        boot_done;
  logic        redirect_take;
  logic        misaligned_take;
  logic        out_free;
  logic        want_fire;
  logic        pc_in_range;
  logic        fire;
  logic        range_fault;
  fetch_word_t fetch_word;

  assign boot_done       = (state == FETCH_STATE_BOOT) && (boot_count == BOOT_LAST);
  assign redirect_take   = redirect_valid && ((state == FETCH_STATE_FETCH) || boot_done);
  assign misaligned_take = redirect_take && (redirect_pc[1:0] != 2'b00);

  // A fetch is wanted when decode can take a word and nothing outranks it;
  // the range check then decides between a real fire and a fault.
  assign out_free    = !out_bus.out_valid || out_bus.out_ready;
  assign want_fire   = (state == FETCH_STATE_FETCH) && !redirect_valid
                       && !halt_request && out_free;
  assign pc_in_range = ({1'b0, pc} < PC_LIMIT);
  assign fire        = want_fire && pc_in_range;
  assign range_fault = want_fire && !pc_in_range;

  assign pc_seq       = pc + PC_INCREMENT;
  assign imem_address = pc[SIZE_EXP2+1:2];
  assign fetch_word   = '{instruction: imem_data, pc: pc, pc_plus4: pc_seq};

  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      FETCH_STATE_BOOT: begin
        if (boot_done) state_next = FETCH_STATE_FETCH;
      end
      FETCH_STATE_FETCH: begin
        // A same-cycle redirect wins; a persisting halt is taken next cycle.
        if (!redirect_valid && (halt_request || range_fault)) begin
          state_next = FETCH_STATE_HALT;
        end
      end
      FETCH_STATE_HALT: state_next = FETCH_STATE_HALT;
      default:          state_next = FETCH_STATE_HALT;
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state      <= FETCH_STATE_BOOT;
      boot_count <= '0;
      pc         <= RESET_PC;
      fault_q    <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == FETCH_STATE_BOOT) && !boot_done) begin
        boot_count <= boot_count + 4'd1;
      end
      if (redirect_take) begin
        pc <= align_word(redirect_pc);
      end else if (fire) begin
        pc <= pc_seq;
      end
      if (misaligned_take || range_fault) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign halted = (state == FETCH_STATE_HALT);
  assign fault  = fault_q;

  fetch_output_register u_output_register (
    .clk       (system_clock),
    .rst       (system_reset),
    .load      (fire),
    .flush     (redirect_take),
    .load_word (fetch_word),
    .out_bus   (out_bus)
  );

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Scoreboard bench: a cycle-level reference model predicts the registered
// outputs after every edge; a negedge monitor pops and compares them.
module tb_instruction_fetch_controller;
  import instruction_fetch_controller_pkg::*;

  localparam int          SIZE_EXP2   = 6;
  localparam int          BOOT_CYCLES = 2;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] LIMIT       = 32'd4 << SIZE_EXP2;
  localparam int          WORDS       = 1 << SIZE_EXP2;

  logic                 system_clock = 1'b0;
  logic                 system_reset;
  logic [SIZE_EXP2-1:0] imem_address;
  logic [31:0]          imem_data;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 halt_request;
  logic                 halted;
  logic                 fault;

  logic [31:0] mem [0:WORDS-1];

  instruction_fetch_controller_if bus ();

  instruction_fetch_controller #(
    .SIZE_EXP2   (SIZE_EXP2),
    .RESET_PC    (RESET_PC),
    .BOOT_CYCLES (BOOT_CYCLES)
  ) dut (
    .system_clock   (system_clock),
    .system_reset   (system_reset),
    .imem_address   (imem_address),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_request   (halt_request),
    .out_bus        (bus),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 system_clock = ~system_clock;
  assign imem_data = mem[imem_address];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: architectural view of the fetch unit.
  logic [31:0] m_pc;
  int          m_boot_left;
  bit          m_halted, m_fault, m_valid;
  logic [31:0] m_instr, m_opc, m_opc4;

  typedef struct packed {
    logic        valid;
    logic        halted;
    logic        fault;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;
  exp_t exp_q[$];

  task automatic model_step(input bit rst, input bit rv, input logic [31:0] rpc,
                            input bit h, input bit rdy);
    if (rst) begin
      m_pc = RESET_PC; m_boot_left = BOOT_CYCLES;
      m_halted = 0; m_fault = 0; m_valid = 0;
      m_instr = 0; m_opc = 0; m_opc4 = 0;
    end else if (m_boot_left > 0) begin
      m_boot_left--;
    end else if (m_halted) begin
      if (m_valid && rdy) m_valid = 0;
    end else if (rv) begin
      m_pc = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) m_fault = 1;
      m_valid = 0;
    end else if (h) begin
      m_halted = 1;
      if (m_valid && rdy) m_valid = 0;
    end else if (!m_valid || rdy) begin
      if (m_pc >= LIMIT) begin
        m_fault = 1; m_halted = 1; m_valid = 0;
      end else begin
        m_instr = mem[m_pc / 4];
        m_opc   = m_pc;
        m_opc4  = m_pc + 32'd4;
        m_valid = 1;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  // Drives one cycle of inputs, lets the edge happen, then records the
  // state the model expects the DUT to show after that edge.
  task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc,
                       input bit h, input bit rdy);
    exp_t e;
    system_reset   = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_request   = h;
    bus.out_ready  = rdy;
    @(posedge system_clock);
    #1;
    model_step(rst, rv, rpc, h, rdy);
    e.valid  = m_valid;
    e.halted = m_halted;
    e.fault  = m_fault;
    e.addr   = (m_pc / 4) % WORDS;
    e.instr  = m_instr;
    e.pc     = m_opc;
    e.pc4    = m_opc4;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  // Monitor: compares every presented output against the scoreboard.
  initial begin
    forever begin
      @(negedge system_clock);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_valid",       32'(bus.out_valid), 32'(e.valid));
        check("halted",          32'(halted),        32'(e.halted));
        check("fault",           32'(fault),         32'(e.fault));
        check("imem_address",    32'(imem_address),  e.addr);
        check("out_instruction", bus.out_instruction, e.instr);
        check("out_pc",          bus.out_pc,          e.pc);
        check("out_pc_plus4",    bus.out_pc_plus4,    e.pc4);
      end
    end
  end

  initial begin
    logic [31:0] target;
    for (int i = 0; i < WORDS; i++) mem[i] = (i < 4) ? 32'(11 * (i + 1)) : 32'(i);
    system_reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    halt_request = 1'b0; bus.out_ready = 1'b1;

    // Reset, boot latency and sequential fetch.
    cycle(1, 0, 0, 0, 1); cycle(1, 0, 0, 0, 1);
    @(negedge system_clock);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_pc", bus.out_pc, 32'h0);
    idle(2, 1);
    @(negedge system_clock);
    check("boot_no_valid", 32'(bus.out_valid), 32'd0);
    idle(1, 1);
    @(negedge system_clock);
    check("first_word", bus.out_instruction, 32'd11);
    idle(1, 1);

    // Stall holds outputs and the memory address.
    idle(3, 0);
    @(negedge system_clock);
    check("stall_instr", bus.out_instruction, 32'd22);
    check("stall_pc", bus.out_pc, 32'h4);
    check("stall_pc_plus4", bus.out_pc_plus4, 32'h8);
    check("stall_addr", 32'(imem_address), 32'd2);
    idle(1, 1);
    @(negedge system_clock);
    check("after_stall_pc", bus.out_pc, 32'h8);
    idle(1, 1);
    idle(1, 0);

    // Redirect flushes a stalled word.
    cycle(0, 1, 32'h40, 0, 0);
    @(negedge system_clock);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    idle(1, 1);
    @(negedge system_clock);
    check("redirect_pc", bus.out_pc, 32'h40);
    check("redirect_word", bus.out_instruction, 32'd16);

    // Misaligned redirect faults and aligns.
    cycle(0, 1, 32'h42, 0, 1);
    @(negedge system_clock);
    check("misaligned_fault", 32'(fault), 32'd1);
    idle(1, 1);
    @(negedge system_clock);
    check("misaligned_pc", bus.out_pc, 32'h40);

    // Last in-range word, then range fault into HALT.
    cycle(1, 0, 0, 0, 1); cycle(1, 0, 0, 0, 1);
    idle(2, 1);
    cycle(0, 1, LIMIT - 32'd4, 0, 1);
    idle(1, 1);
    @(negedge system_clock);
    check("last_word", bus.out_instruction, 32'(WORDS - 1));
    idle(1, 1);
    @(negedge system_clock);
    check("range_fault", 32'(fault), 32'd1);
    check("range_halted", 32'(halted), 32'd1);
    idle(2, 1);

    // Reset during HALT, then halt with a stalled word.
    cycle(1, 0, 0, 0, 1);
    @(negedge system_clock);
    check("halt_reset_fault", 32'(fault), 32'd0);
    check("halt_reset_halted", 32'(halted), 32'd0);
    cycle(1, 0, 0, 0, 1);
    idle(2, 1);
    idle(1, 1);
    cycle(0, 0, 0, 1, 0);
    @(negedge system_clock);
    check("halt_entered", 32'(halted), 32'd1);
    check("halt_held_valid", 32'(bus.out_valid), 32'd1);
    idle(1, 0);
    idle(4, 1);
    @(negedge system_clock);
    check("halt_drained", 32'(bus.out_valid), 32'd0);
    check("halt_no_fire_pc", bus.out_pc, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit r, rv, h, rdy;
      r   = ($urandom_range(0, 99) == 0);
      rv  = (m_boot_left == 0) && ($urandom_range(0, 99) < 8);
      h   = ($urandom_range(0, 99) < 2);
      rdy = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 4))
        0, 1:    target = 32'($urandom_range(0, WORDS - 1)) * 32'd4;
        2:       target = 32'($urandom_range(0, WORDS - 1)) * 32'd4 + 32'($urandom_range(1, 3));
        3:       target = LIMIT - 32'd4 * 32'($urandom_range(1, 2));
        default: target = ($urandom_range(0, 1) == 0) ? LIMIT : 32'hFFFF_FFFC;
      endcase
      cycle(r, rv, target, h, rdy);
    end

    idle(1, 1);
    @(negedge system_clock);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
